vector_issue_queue: RTL and testbench

- Front end of the vector pipeline: buffers vector instructions and their vsew from the scalar core, then issues them one per cycle into the vector datapath's instruction/vsew/load inputs.
- Inserts NOP bubbles on read-after-write hazards that datapath forwarding cannot cover.
- Sits between scalar decode and the vector datapath's IF/VID latch. Drives its `load` and `flush` controls.

---
 rtl/vector_issue_queue.sv | 183 ++++++++++++++++++
 tb/tb_vector_issue_queue.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_issue_queue.sv
// rtl/vector_issue_queue.sv - vector instruction FIFO with RAW hazard bubbling; optional bypass via VECTOR_ISSUE_BYPASS_EN
module vector_issue_queue #(
    parameter int                            INSTRUCTION_LENGTH = 32,
    parameter int                            DEPTH              = 4,
    parameter int                            HAZARD_DEPTH       = 2,
    parameter logic [INSTRUCTION_LENGTH-1:0] NOP_INSTR          = '0
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [INSTRUCTION_LENGTH-1:0] in_instruction_i,
    input  logic [2:0]                    in_vsew_i,
    input  logic                          dp_stall_i,
    output logic                          load_o,
    output logic                          flush_o,
    output logic [INSTRUCTION_LENGTH-1:0] instruction_o,
    output logic [2:0]                    vsew_o,
    output logic                          issued_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_BUBBLE = 2'd2;

    logic [INSTRUCTION_LENGTH-1:0] mem_instr [DEPTH];
    logic [2:0]                    mem_vsew  [DEPTH];
    logic [PTR_W-1:0]              rd_ptr, wr_ptr;
    logic [CNT_W-1:0]              count, count_next;
    logic [1:0]                    state, state_next;
    logic [HAZARD_DEPTH-1:0][4:0]  hist_vd;
    logic [HAZARD_DEPTH-1:0]       hist_wr;

    logic [INSTRUCTION_LENGTH-1:0] head_instr;
    logic [2:0]                    head_vsew;
    logic                          head_valid, head_hazard;
    logic                          can_enq, do_enq, do_issue, do_bypass, advance;
    logic                          slot_wr;
    logic [4:0]                    slot_vd;

    // Vector arithmetic ops write vd; vsetvl-class (funct3=111) writes no vector register
    function automatic logic is_writer(input logic [6:0] op, input logic [2:0] f3);
        return (op == 7'b1010111) && (f3 != 3'b111);
    endfunction

    function automatic logic reads_reg(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] vs1, input logic [4:0] vs2,
                                       input logic [4:0] r);
        logic use_vs1;
        use_vs1 = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return is_writer(op, f3) && ((vs2 == r) || (use_vs1 && (vs1 == r)));
    endfunction

    function automatic logic has_hazard(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] vs1, input logic [4:0] vs2,
                                        input logic [HAZARD_DEPTH-1:0][4:0] vds,
                                        input logic [HAZARD_DEPTH-1:0] wrs);
        logic h;
        h = 1'b0;
        for (int i = 0; i < HAZARD_DEPTH; i++) begin
            if (wrs[i] && reads_reg(op, f3, vs1, vs2, vds[i])) h = 1'b1;
        end
        return h;
    endfunction

    assign in_ready_o = (count < CNT_W'(DEPTH));
    assign count_o    = count;
    assign empty_o    = (count == '0);

    // Issue decision, bypass decision, history slot contents and next state
    always_comb begin
        head_instr  = mem_instr[rd_ptr];
        head_vsew   = mem_vsew[rd_ptr];
        head_valid  = (state != ST_IDLE) && (count != '0);
        head_hazard = has_hazard(head_instr[6:0], head_instr[14:12], head_instr[19:15],
                                 head_instr[24:20], hist_vd, hist_wr);
        advance     = !flush_i && !dp_stall_i;
        can_enq     = in_valid_i && in_ready_o && !flush_i;
        do_issue    = advance && head_valid && !head_hazard;
`ifdef VECTOR_ISSUE_BYPASS_EN
        do_bypass   = can_enq && advance && (state == ST_IDLE) && (count == '0) &&
                      !has_hazard(in_instruction_i[6:0], in_instruction_i[14:12],
                                  in_instruction_i[19:15], in_instruction_i[24:20],
                                  hist_vd, hist_wr);
`else
        do_bypass   = 1'b0;
`endif
        do_enq      = can_enq && !do_bypass;
        count_next  = count + CNT_W'(do_enq) - CNT_W'(do_issue);

        slot_wr = 1'b0;
        slot_vd = '0;
        if (do_issue) begin
            slot_wr = is_writer(head_instr[6:0], head_instr[14:12]);
            slot_vd = head_instr[11:7];
        end else if (do_bypass) begin
            slot_wr = is_writer(in_instruction_i[6:0], in_instruction_i[14:12]);
            slot_vd = in_instruction_i[11:7];
        end

        state_next = ST_ISSUE;
        if (flush_i || (count_next == '0))   state_next = ST_IDLE;
        else if (dp_stall_i)                 state_next = (state == ST_BUBBLE) ? ST_BUBBLE : ST_ISSUE;
        else if (head_valid && head_hazard)  state_next = ST_BUBBLE;
    end

    // FIFO storage; contents are don't-care while not counted as occupied
    always_ff @(posedge clk_i) begin
        if (do_enq) begin
            mem_instr[wr_ptr] <= in_instruction_i;
            mem_vsew[wr_ptr]  <= in_vsew_i;
        end
    end

    // Pointers, occupancy, state and issue-slot history
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            state   <= ST_IDLE;
            hist_vd <= '0;
            hist_wr <= '0;
        end else if (flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            state   <= ST_IDLE;
            hist_wr <= '0;
        end else begin
            if (do_enq)   wr_ptr <= wr_ptr + 1'b1;
            if (do_issue) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            state <= state_next;
            if (advance) begin
                for (int i = HAZARD_DEPTH - 1; i > 0; i--) begin
                    hist_vd[i] <= hist_vd[i-1];
                    hist_wr[i] <= hist_wr[i-1];
                end
                hist_vd[0] <= slot_vd;
                hist_wr[0] <= slot_wr;
            end
        end
    end

    // Registered datapath-facing outputs; a stall freezes the issued instruction
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            instruction_o <= NOP_INSTR;
            vsew_o        <= '0;
            issued_o      <= 1'b0;
            load_o        <= 1'b0;
            flush_o       <= 1'b0;
        end else begin
            load_o  <= !dp_stall_i;
            flush_o <= flush_i;
            if (flush_i) begin
                instruction_o <= NOP_INSTR;
                vsew_o        <= '0;
                issued_o      <= 1'b0;
            end else if (dp_stall_i) begin
                issued_o <= 1'b0;
            end else if (do_issue) begin
                instruction_o <= head_instr;
                vsew_o        <= head_vsew;
                issued_o      <= 1'b1;
            end else if (do_bypass) begin
                instruction_o <= in_instruction_i;
                vsew_o        <= in_vsew_i;
                issued_o      <= 1'b1;
            end else begin
                instruction_o <= NOP_INSTR;
                vsew_o        <= '0;
                issued_o      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vector_issue_queue.sv
// tb/tb_vector_issue_queue.sv - randomized and scenario bench for vector_issue_queue against a queue-level model
module tb_vector_issue_queue;
    localparam int DEPTH = 4;
    localparam int HD    = 2;

    logic        clk = 1'b0;
    logic        rstn, flush, in_valid, dp_stall;
    logic [31:0] in_instr;
    logic [2:0]  in_vsew;
    logic        in_ready, load, flush_out, issued, empty;
    logic [31:0] instr_out;
    logic [2:0]  vsew_out;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    vector_issue_queue #(.INSTRUCTION_LENGTH(32), .DEPTH(DEPTH), .HAZARD_DEPTH(HD), .NOP_INSTR(32'h0)) dut (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_instruction_i(in_instr), .in_vsew_i(in_vsew), .dp_stall_i(dp_stall), .load_o(load),
        .flush_o(flush_out), .instruction_o(instr_out), .vsew_o(vsew_out), .issued_o(issued),
        .count_o(count), .empty_o(empty)
    );

    always #5 clk = ~clk;

    // Reference model: pending queue plus the last HD issue slots (vd, writes-vector flag)
    typedef struct { logic [31:0] ins; logic [2:0] sew; } entry_t;
    entry_t      mq[$];
    int          h_vd[HD];
    bit          h_w[HD];
    logic [31:0] e_instr;
    logic [2:0]  e_vsew;
    bit          e_issued, e_load, e_flush, m_acc;

    function automatic bit m_writer(input logic [31:0] x);
        return (x[6:0] == 7'h57) && (x[14:12] != 3'd7);
    endfunction

    function automatic bit m_reads(input logic [31:0] x, input int r);
        if (!m_writer(x)) return 0;
        if (int'(x[24:20]) == r) return 1;
        return (x[14:12] <= 3'd2) && (int'(x[19:15]) == r);
    endfunction

    function automatic bit m_hazard(input logic [31:0] x);
        for (int i = 0; i < HD; i++) if (h_w[i] && m_reads(x, h_vd[i])) return 1;
        return 0;
    endfunction

    task automatic m_slot(input bit w, input int vd);
        for (int i = HD - 1; i > 0; i--) begin h_w[i] = h_w[i-1]; h_vd[i] = h_vd[i-1]; end
        h_w[0] = w; h_vd[0] = vd;
    endtask

    task automatic m_reset();
        mq.delete();
        for (int i = 0; i < HD; i++) begin h_w[i] = 0; h_vd[i] = 0; end
        e_instr = 0; e_vsew = 0; e_issued = 0; e_load = 0; e_flush = 0;
    endtask

    function automatic logic [31:0] vadd(input int vd, input int vs2, input int vs1);
        logic [4:0] d, a, b;
        d = vd[4:0]; a = vs2[4:0]; b = vs1[4:0];
        return {7'b0000001, a, b, 3'b000, d, 7'h57};
    endfunction

    // Drive one cycle, advance the model, then sample 1 time unit after the edge
    task automatic cycle(input bit f, input bit v, input logic [31:0] ins, input logic [2:0] sew, input bit st);
        bit bypassed;
        flush = f; in_valid = v; in_instr = ins; in_vsew = sew; dp_stall = st;
        m_acc = v && (mq.size() < DEPTH) && !f;
        e_load = !st; e_flush = f; bypassed = 0;
        if (f) begin
            mq.delete();
            for (int i = 0; i < HD; i++) h_w[i] = 0;
            e_instr = 0; e_vsew = 0; e_issued = 0;
        end else if (st) begin
            e_issued = 0;
            if (m_acc) mq.push_back('{ins, sew});
        end else begin
            if (mq.size() > 0 && !m_hazard(mq[0].ins)) begin
                e_instr = mq[0].ins; e_vsew = mq[0].sew; e_issued = 1;
                m_slot(m_writer(mq[0].ins), int'(mq[0].ins[11:7]));
                void'(mq.pop_front());
            end
`ifdef VECTOR_ISSUE_BYPASS_EN
            else if (mq.size() == 0 && m_acc && !m_hazard(ins)) begin
                e_instr = ins; e_vsew = sew; e_issued = 1; bypassed = 1;
                m_slot(m_writer(ins), int'(ins[11:7]));
            end
`endif
            else begin
                e_instr = 0; e_vsew = 0; e_issued = 0;
                m_slot(0, 0);
            end
            if (m_acc && !bypassed) mq.push_back('{ins, sew});
        end
        @(posedge clk); #1;
    endtask

    // Fill under stall, release, and report NOP cycles between the last two issues
    task automatic measure_gap(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2,
                               input int n, output int gap, output int gap01);
        logic [31:0] seq[3];
        int t_iss[$];
        seq[0] = i0; seq[1] = i1; seq[2] = i2;
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) cycle(0, 1, seq[k], 3'(k + 1), 1);
        for (int c = 0; c < 20; c++) begin
            cycle(0, 0, 0, 0, 0);
            if (issued) t_iss.push_back(c);
        end
        gap = -1; gap01 = -1;
        if (t_iss.size() == n) begin
            gap   = t_iss[n-1] - t_iss[n-2] - 1;
            gap01 = t_iss[1] - t_iss[0] - 1;
        end
    endtask

    task automatic test_reset();
        rstn = 0; flush = 0; in_valid = 0; dp_stall = 0; in_instr = 0; in_vsew = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (instr_out !== 32'h0 || vsew_out !== 3'd0 || issued !== 1'b0 || load !== 1'b0 ||
            flush_out !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: instr=%h vsew=%0d issued=%b load=%b flush=%b count=%0d empty=%b ready=%b, required 0/0/0/0/0/0/1/1",
                     instr_out, vsew_out, issued, load, flush_out, count, empty, in_ready);
        end
        rstn = 1;
        for (int c = 0; c < 4; c++) begin
            cycle(0, 0, 0, 0, 0);
            tests++;
            if (load !== 1'b1 || issued !== 1'b0 || instr_out !== 32'h0 || empty !== 1'b1) begin
                fails++;
                $display("FAIL idle_cycle%0d: load=%b issued=%b instr=%h empty=%b, required 1/0/0/1", c, load, issued, instr_out, empty);
            end
        end
    endtask

    task automatic test_stream();
        logic [31:0] got[$];
        int next, first, last, nops;
        cycle(1, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            cycle(0, 1, vadd(k, 10, 11), 3'(k), 1);
            tests++;
            if (int'(count) !== k || in_ready !== (k < DEPTH)) begin
                fails++;
                $display("FAIL fill_count%0d: count=%0d ready=%b, required %0d/%b", k, count, in_ready, k, k < DEPTH);
            end
        end
        cycle(0, 1, vadd(5, 10, 11), 3'd5, 1);
        tests++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_hold: count=%0d ready=%b, required 4/0", count, in_ready);
        end
        next = 5; first = -1; last = -1; nops = 0;
        for (int c = 0; c < 30; c++) begin
            cycle(0, next <= 6, vadd(next, 10, 11), 3'(next), 0);
            if (m_acc) next++;
            if (issued) begin
                got.push_back(instr_out);
                if (first < 0) first = c;
                last = c;
            end else if (first >= 0 && got.size() < 6) nops++;
        end
        tests++;
        if (got.size() !== 6) begin
            fails++;
            $display("FAIL stream_count: issued %0d, required 6", got.size());
        end
        for (int k = 0; k < got.size() && k < 6; k++) begin
            tests++;
            if (got[k] !== vadd(k + 1, 10, 11)) begin
                fails++;
                $display("FAIL stream_order%0d: got %h, required %h", k, got[k], vadd(k + 1, 10, 11));
            end
        end
        tests++;
        if (nops !== 0 || last - first !== 5) begin
            fails++;
            $display("FAIL stream_gapless: nops=%0d span=%0d, required 0/5", nops, last - first);
        end
    endtask

    task automatic test_hazard();
        int gap, gap01;
        measure_gap(vadd(3, 1, 2), vadd(4, 3, 5), 0, 2, gap, gap01);
        tests++;
        if (gap !== 2) begin
            fails++;
            $display("FAIL hazard_dist1: bubbles=%0d, required 2", gap);
        end
        measure_gap(vadd(3, 1, 2), vadd(7, 10, 11), vadd(4, 3, 5), 3, gap, gap01);
        tests++;
        if (gap !== 1 || gap01 !== 0) begin
            fails++;
            $display("FAIL hazard_dist2: bubbles=%0d first_gap=%0d, required 1/0", gap, gap01);
        end
        measure_gap({1'b1, 6'd0, 5'd2, 5'd1, 3'b111, 5'd0, 7'h57}, vadd(4, 0, 0), 0, 2, gap, gap01);
        tests++;
        if (gap !== 0) begin
            fails++;
            $display("FAIL hazard_vsetvl: bubbles=%0d, required 0", gap);
        end
    endtask

    task automatic test_stall();
        logic [31:0] got[$];
        logic [31:0] frz_i;
        logic [2:0]  frz_s;
        int next, stalled;
        bit st;
        cycle(1, 0, 0, 0, 0);
        next = 1; stalled = 0; frz_i = 0; frz_s = 0;
        for (int c = 0; c < 40; c++) begin
            st = (got.size() >= 2) && (stalled < 3);
            if (st && stalled == 0) begin frz_i = instr_out; frz_s = vsew_out; end
            cycle(0, next <= 6, vadd(next + 16, 10, 11), 3'(next), st);
            if (m_acc) next++;
            if (st) begin
                stalled++;
                tests++;
                if (instr_out !== frz_i || vsew_out !== frz_s || load !== 1'b0 || issued !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_freeze%0d: instr=%h vsew=%0d load=%b issued=%b, required %h/%0d/0/0",
                             stalled, instr_out, vsew_out, load, issued, frz_i, frz_s);
                end
            end
            if (issued) got.push_back(instr_out);
        end
        tests++;
        if (got.size() !== 6) begin
            fails++;
            $display("FAIL stall_count: issued %0d, required 6", got.size());
        end
        for (int k = 0; k < got.size() && k < 6; k++) begin
            tests++;
            if (got[k] !== vadd(k + 17, 10, 11)) begin
                fails++;
                $display("FAIL stall_order%0d: got %h, required %h", k, got[k], vadd(k + 17, 10, 11));
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] x;
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, vadd(k + 1, 10, 11), 3'(k), 1);
        cycle(1, 1, vadd(9, 10, 11), 3'd2, 1);
        tests++;
        if (count !== 3'd0 || empty !== 1'b1 || flush_out !== 1'b1 || instr_out !== 32'h0 || issued !== 1'b0) begin
            fails++;
            $display("FAIL flush_state: count=%0d empty=%b flush_o=%b instr=%h issued=%b, required 0/1/1/0/0",
                     count, empty, flush_out, instr_out, issued);
        end
        for (int c = 0; c < 4; c++) begin
            cycle(0, 0, 0, 0, 0);
            tests++;
            if (issued !== 1'b0 || flush_out !== 1'b0 || count !== 3'd0) begin
                fails++;
                $display("FAIL flush_quiet%0d: issued=%b flush_o=%b count=%0d, required 0/0/0", c, issued, flush_out, count);
            end
        end
        x = vadd(12, 13, 14);
        cycle(0, 1, x, 3'd5, 0);
`ifdef VECTOR_ISSUE_BYPASS_EN
        tests++;
        if (issued !== 1'b1 || instr_out !== x || vsew_out !== 3'd5) begin
            fails++;
            $display("FAIL bypass_latency: issued=%b instr=%h vsew=%0d, required 1/%h/5", issued, instr_out, vsew_out, x);
        end
`else
        tests++;
        if (issued !== 1'b0 || count !== 3'd1) begin
            fails++;
            $display("FAIL fifo_latency_edge1: issued=%b count=%0d, required 0/1", issued, count);
        end
        cycle(0, 0, 0, 0, 0);
        tests++;
        if (issued !== 1'b1 || instr_out !== x || vsew_out !== 3'd5) begin
            fails++;
            $display("FAIL fifo_latency_edge2: issued=%b instr=%h vsew=%0d, required 1/%h/5", issued, instr_out, vsew_out, x);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] x;
        bit f, v, st;
        cycle(1, 0, 0, 0, 0);
        for (int c = 0; c < 800; c++) begin
            f  = ($urandom % 50) == 0;
            v  = ($urandom % 3) != 0;
            st = ($urandom % 5) == 0;
            x  = {7'($urandom), 5'($urandom % 4), 5'($urandom % 4), 3'($urandom),
                  5'($urandom % 4), (($urandom % 5) == 0) ? 7'h33 : 7'h57};
            cycle(f, v, x, 3'($urandom), st);
            tests++;
            if (instr_out !== e_instr || vsew_out !== e_vsew || issued !== e_issued || load !== e_load ||
                flush_out !== e_flush || int'(count) !== mq.size() || empty !== (mq.size() == 0) ||
                in_ready !== (mq.size() < DEPTH)) begin
                fails++;
                $display("FAIL random_cycle%0d: instr=%h vsew=%0d issued=%b load=%b flush=%b count=%0d, required %h/%0d/%b/%b/%b/%0d",
                         c, instr_out, vsew_out, issued, load, flush_out, count,
                         e_instr, e_vsew, e_issued, e_load, e_flush, mq.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, vadd(k + 1, 10, 11), 3'(k + 1), 0);
        #2 rstn = 0;
        #1;
        tests++;
        if (instr_out !== 32'h0 || vsew_out !== 3'd0 || issued !== 1'b0 || load !== 1'b0 ||
            count !== 3'd0 || empty !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: instr=%h vsew=%0d issued=%b load=%b count=%0d empty=%b ready=%b, required 0/0/0/0/0/1/1",
                     instr_out, vsew_out, issued, load, count, empty, in_ready);
        end
        @(posedge clk); #1;
        rstn = 1;
        m_reset();
        cycle(0, 0, 0, 0, 0);
        tests++;
        if (issued !== 1'b0 || count !== 3'd0 || load !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_after: issued=%b count=%0d load=%b, required 0/0/1", issued, count, load);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hazard();
        test_stall();
        test_flush();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
